// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator arbiter: FSM states and the fixed
// operand width of the shared magnitude comparator.
package cmp_pkg;

    localparam int CMP_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_arbiter_if.sv
// Request/response bundle between the requesters, the arbiter and the
// response consumer. master = requester/consumer side, slave = arbiter side.
interface cmp_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int WIDTH = cmp_pkg::CMP_WIDTH
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_gt;
    logic                   rsp_eq;
    logic                   rsp_lt;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt
    );
endinterface

// File: rtl/cmp_arbiter_mag.sv
// Unsigned magnitude comparator shared by all requesters.
module cmp_arbiter_mag #(
    parameter int WIDTH = cmp_pkg::CMP_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_ls_b
);
    assign a_gt_b = (a > b);
    assign a_eq_b = (a == b);
    assign a_ls_b = (a < b);
endmodule

// File: rtl/rr_pick.sv
// Round-robin pick: first set bit of req searching ptr, ptr+1, ... mod N_REQ.
// Returns a one-hot grant, its index, and whether anything was found.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             found
);
    logic [2*N_REQ-1:0]           req_dbl;
    logic [N_REQ-1:0]             rot;
    logic [N_REQ-1:0]             taken;
    logic [N_REQ-1:0]             first;
    logic [2*N_REQ-1:0]           grant_dbl;
    logic [N_REQ-1:0][ID_W-1:0]   idx_acc;

    // Rotate so that position 0 is the pointer, pick lowest set bit, rotate back.
    assign req_dbl = {req, req};
    assign rot     = req_dbl[ptr +: N_REQ];

    assign taken[0] = 1'b0;
    assign first[0] = rot[0];
    assign idx_acc[0] = '0;

    genvar gi;
    for (gi = 1; gi < N_REQ; gi++) begin : g_first
        assign taken[gi] = taken[gi-1] | rot[gi-1];
        assign first[gi] = rot[gi] & ~taken[gi];
    end

    assign grant_dbl = {{N_REQ{1'b0}}, first} << ptr;
    assign grant     = grant_dbl[N_REQ-1:0] | grant_dbl[2*N_REQ-1:N_REQ];

    for (gi = 1; gi < N_REQ; gi++) begin : g_idx
        assign idx_acc[gi] = idx_acc[gi-1] | (grant[gi] ? ID_W'(gi) : '0);
    end

    assign idx   = idx_acc[N_REQ-1];
    assign found = |req;
endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator among N_REQ requesters;
// each accepted pair takes IDLE -> COMPARE -> RESPOND before the next grant.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int WIDTH = CMP_WIDTH
) (
    input logic          clk,
    input logic          rst,
    cmp_arbiter_if.slave bus
);
    state_t                       state_reg, state_next;
    logic [ID_W-1:0]              rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0]              id_reg;
    logic [WIDTH-1:0]             op_a_reg, op_b_reg;
    logic                         rsp_valid_reg, rsp_gt_reg, rsp_eq_reg, rsp_lt_reg;
    logic [ID_W-1:0]              rsp_id_reg;
    logic [N_REQ-1:0]             req_ready_next;
    logic                         accept;

    logic [N_REQ-1:0]             pick_grant;
    logic [ID_W-1:0]              pick_idx;
    logic                         pick_found;
    logic                         cmp_gt, cmp_eq, cmp_lt;
    logic [N_REQ-1:0][WIDTH-1:0]  a_vec, b_vec;

    assign a_vec = bus.req_a;
    assign b_vec = bus.req_b;

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // The comparator only ever sees the latched operands of the granted requester.
    cmp_arbiter_mag #(.WIDTH(WIDTH)) u_mag (
        .a      (op_a_reg),
        .b      (op_b_reg),
        .a_gt_b (cmp_gt),
        .a_eq_b (cmp_eq),
        .a_ls_b (cmp_lt)
    );

    assign rr_ptr_next = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);

    always_comb begin
        state_next     = state_reg;
        req_ready_next = '0;
        accept         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!rst) begin
                    req_ready_next = pick_grant;
                end
                if (pick_found) begin
                    accept     = 1'b1;
                    state_next = ST_COMPARE;
                end
            end
            ST_COMPARE: state_next = ST_RESPOND;
            ST_RESPOND: begin
                if (bus.rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= '0;
            id_reg        <= '0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_gt_reg    <= 1'b0;
            rsp_eq_reg    <= 1'b0;
            rsp_lt_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_a_reg   <= a_vec[pick_idx];
                op_b_reg   <= b_vec[pick_idx];
                id_reg     <= pick_idx;
                rr_ptr_reg <= rr_ptr_next;
            end
            // Flags are only loaded here, so they keep their value after rsp_valid drops.
            if (state_reg == ST_COMPARE) begin
                rsp_valid_reg <= 1'b1;
                rsp_id_reg    <= id_reg;
                rsp_gt_reg    <= cmp_gt;
                rsp_eq_reg    <= cmp_eq;
                rsp_lt_reg    <= cmp_lt;
            end else if (state_reg == ST_RESPOND && bus.rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.req_ready = req_ready_next;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_gt    = rsp_gt_reg;
    assign bus.rsp_eq    = rsp_eq_reg;
    assign bus.rsp_lt    = rsp_lt_reg;
endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: directed scenarios plus random traffic
// compared each cycle against a transaction-level reference model.
module tb_cmp_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    logic [3:0]  v_drv;
    logic [15:0] a_drv, b_drv;
    logic        rr_drv;

    always #5 clk = ~clk;

    cmp_arbiter_if #(.N_REQ(4), .ID_W(2), .WIDTH(4)) bus ();

    cmp_arbiter #(.N_REQ(4), .ID_W(2), .WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.req_valid = v_drv;
    assign bus.req_a     = a_drv;
    assign bus.req_b     = b_drv;
    assign bus.rsp_ready = rr_drv;

    int errors = 0;
    int checks = 0;

    // Reference model: free/busy, cycles since accept, pending and shown response.
    bit   m_free;
    int   m_age;
    int   m_ptr;
    bit   m_rv;
    int   m_id;
    bit   m_gt, m_eq, m_lt;
    int   p_id;
    bit   p_gt, p_eq, p_lt;
    int   g;
    logic [9:0] exp_vec, obs_vec;

    function automatic int first_valid(input logic [3:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_free = 1; m_age = 0; m_ptr = 0; m_rv = 0; m_id = 0;
        m_gt = 0; m_eq = 0; m_lt = 0;
    endtask

    task automatic apply(input logic r, input logic [3:0] v, input logic [15:0] a,
                         input logic [15:0] b, input logic rr);
        rst = r; v_drv = v; a_drv = a; b_drv = b; rr_drv = rr;
        @(negedge clk);
        g = (r || !m_free) ? -1 : first_valid(v, m_ptr);
        exp_vec = {(g >= 0) ? 4'(1 << g) : 4'b0, m_rv, m_id[1:0], m_gt, m_eq, m_lt};
        obs_vec = {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_gt, bus.rsp_eq, bus.rsp_lt};
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (g >= 0) begin
            p_id = g;
            p_gt = a_drv[g*4 +: 4] >  b_drv[g*4 +: 4];
            p_eq = a_drv[g*4 +: 4] == b_drv[g*4 +: 4];
            p_lt = a_drv[g*4 +: 4] <  b_drv[g*4 +: 4];
            m_free = 0; m_age = 0; m_ptr = (g + 1) % N;
        end else if (!m_free) begin
            if (m_age == 0) begin
                m_age = 1; m_rv = 1; m_id = p_id;
                m_gt = p_gt; m_eq = p_eq; m_lt = p_lt;
            end else if (rr_drv) begin
                m_rv = 0; m_free = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        apply(1'b1, 4'b0, 16'h0, 16'h0, 1'b1);
        advance();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 4'hF, 16'($urandom), 16'($urandom), 1'b1);
            checks++;
            if (obs_vec !== 10'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, obs_vec, 10'b0);
            end
            advance();
        end
        apply(1'b0, 4'hF, 16'($urandom), 16'($urandom), 1'b1);
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant got=%b want=%b", bus.req_ready, 4'b0001);
        end
        advance();
    endtask

    task automatic test_single();
        logic [15:0] a, b;
        logic [9:0]  want [4];
        want = '{10'b0100_0_00_000, 10'b0000_0_00_000, 10'b0000_1_10_100, 10'b0100_0_10_100};
        do_reset();
        a = 16'($urandom); b = 16'($urandom);
        a[11:8] = 4'b0111; b[11:8] = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 4'b0100, a, b, 1'b1);
            checks++;
            if (obs_vec !== want[i]) begin
                errors++;
                $display("FAIL single cyc=%0d got=%b want=%b", i, obs_vec, want[i]);
            end
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL single_model cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_round_robin();
        int         grants [$];
        logic [4:0] rsps [$];
        int         want_g [5];
        logic [4:0] want_r [4];
        int         got_g;
        logic [4:0] got_r;
        want_g = '{0, 1, 2, 3, 0};
        want_r = '{5'b00_010, 5'b01_100, 5'b10_001, 5'b11_100};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            apply(1'b0, 4'hF, {4'd15, 4'd2, 4'd1, 4'd0}, {4'd1, 4'd3, 4'd0, 4'd0}, 1'b1);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL rr_model cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            for (int k = 0; k < N; k++) if (bus.req_ready[k]) grants.push_back(k);
            if (bus.rsp_valid) rsps.push_back({bus.rsp_id, bus.rsp_gt, bus.rsp_eq, bus.rsp_lt});
            advance();
        end
        for (int i = 0; i < 5; i++) begin
            got_g = (i < grants.size()) ? grants[i] : -1;
            checks++;
            if (got_g !== want_g[i]) begin
                errors++;
                $display("FAIL rr_grant n=%0d got=%0d want=%0d", i, got_g, want_g[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            got_r = (i < rsps.size()) ? rsps[i] : 5'bxxxxx;
            checks++;
            if (got_r !== want_r[i]) begin
                errors++;
                $display("FAIL rr_rsp n=%0d got=%b want=%b", i, got_r, want_r[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] a, b;
        do_reset();
        a = {12'($urandom), 4'b0000};
        b = {12'($urandom), 4'b1111};
        for (int i = 0; i < 9; i++) begin
            apply(1'b0, 4'b0001, a, b, (i >= 7));
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL stall_model cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            if (i >= 2 && i <= 7) begin
                checks++;
                if (obs_vec !== 10'b0000_1_00_001) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d got=%b want=%b", i, obs_vec, 10'b0000_1_00_001);
                end
            end
            if (i == 8) begin
                checks++;
                if (bus.req_ready !== 4'b0001) begin
                    errors++;
                    $display("FAIL stall_regrant got=%b want=%b", bus.req_ready, 4'b0001);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        logic       r_t  [10];
        logic [3:0] v_t  [10];
        logic       rr_t [10];
        r_t  = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
        v_t  = '{4'b0100, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        rr_t = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply(r_t[i], v_t[i], 16'($urandom), 16'($urandom), rr_t[i]);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL rstmid_model cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            if (i == 2 || i == 5) begin
                checks++;
                if (obs_vec !== 10'b0001_0_00_000) begin
                    errors++;
                    $display("FAIL rstmid_after cyc=%0d got=%b want=%b", i, obs_vec, 10'b0001_0_00_000);
                end
            end
            advance();
        end
    endtask

    task automatic test_withdraw();
        logic [3:0] v;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            v = (i == 0) ? 4'b0001 : (i == 1) ? 4'b0011 : 4'b0000;
            apply(1'b0, v, 16'($urandom), 16'($urandom), 1'b1);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL withdraw_model cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            if (i >= 3) begin
                checks++;
                if (obs_vec[9:5] !== 5'b0) begin
                    errors++;
                    $display("FAIL withdraw_idle cyc=%0d got=%b want=%b", i, obs_vec[9:5], 5'b0);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 59) == 0), 4'($urandom), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) != 0));
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            if (bus.rsp_valid === 1'b1) begin
                checks++;
                if (!$onehot({bus.rsp_gt, bus.rsp_eq, bus.rsp_lt})) begin
                    errors++;
                    $display("FAIL onehot cyc=%0d got=%b want=one-hot", i,
                             {bus.rsp_gt, bus.rsp_eq, bus.rsp_lt});
                end
            end
            advance();
        end
    endtask

    initial begin
        model_reset();
        g = -1;
        rst = 1'b1; v_drv = 4'hF; a_drv = '0; b_drv = '0; rr_drv = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
Shares one 4-bit magnitude comparator instance (a_gt_b / a_eq_b / a_ls_b) among N_REQ requesters. Each requester offers an operand pair over a valid/ready handshake. A round-robin scheduler grants one requester at a time, sequences the operands through the comparator, and returns the result tagged with the requester index over a valid/ready response channel. The block sits between the requesters and the shared comparator datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, response index width, equal to clog2(N_REQ), minimum 1
WIDTH, 4, operand width; fixed at 4 to match the shared comparator

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
req_valid  in  N_REQ  bit i set: requester i offers an operand pair
req_ready  out  N_REQ  one-hot grant/accept; bit i pairs with req_valid[i]
req_a  in  N_REQ*WIDTH  operand a, requester i at bits [i*WIDTH +: WIDTH]
req_b  in  N_REQ*WIDTH  operand b, same packing as req_a
rsp_valid  out  1  a response is held
rsp_ready  in  1  consumer accepts the response
rsp_id  out  ID_W  index of the requester served
rsp_gt  out  1  latched a>b
rsp_eq  out  1  latched a==b
rsp_lt  out  1  latched a<b

Behaviour:
- Reset (sync, rst=1 at a clock edge) forces:
  - state=IDLE, rr_ptr=0
  - rsp_valid=0, rsp_id=0, rsp_gt=0, rsp_eq=0, rsp_lt=0
  - operand registers=0, req_ready=0
- rst overrides everything. A request or response in flight is dropped without notice. req_ready is 0 while rst=1.
- FSM states are IDLE, COMPARE, RESPOND.
- IDLE:
  - req_ready is combinational: one-hot for the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod N_REQ. All zeros if no req_valid bit is set.
  - On a handshake (req_valid[g] & req_ready[g]) at the edge: latch req_a[g] and req_b[g] into op_a/op_b, latch g into id_q, set rr_ptr=(g+1) mod N_REQ, go to COMPARE.
- COMPARE:
  - req_ready=0. The comparator is driven only from op_a/op_b.
  - At the edge: latch gt/eq/lt and id_q into the rsp_* registers, set rsp_valid=1, go to RESPOND.
- RESPOND:
  - req_ready=0. rsp_* hold stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid=0 at the edge, go to IDLE.
  - rsp_gt/eq/lt keep their last values after rsp_valid drops.
- Latency: request accepted in cycle t, rsp_valid=1 from cycle t+2. Minimum issue interval is 3 cycles per comparison.
- Exactly one of rsp_gt/rsp_eq/rsp_lt is 1 whenever rsp_valid=1.
- Boundaries:
  - Requester index N_REQ-1 wraps rr_ptr to 0.
  - A requester that drops req_valid before being granted is simply skipped. No state is kept for ungranted requests.
  - Operand values of non-granted requesters are ignored.
  - rsp_ready held low indefinitely stalls the block in RESPOND. No request is accepted during the stall.
  - rsp_ready=1 while rsp_valid=0 has no effect.
  - A single continuously valid requester is served every 3 cycles (4 if rsp_ready is late). Fairness applies only among competing requesters.
- Comparison is unsigned, WIDTH bits.

Decomposition:
- Shared package (cmp_pkg):
  - state encoding constants ST_IDLE=2'd0, ST_COMPARE=2'd1, ST_RESPOND=2'd2
  - CMP_WIDTH=4
- Sub-module: the existing comparator instantiated once inside cmp_arbiter (ports a, b, a_gt_b, a_eq_b, a_ls_b).
- The round-robin pick is a natural second sub-module: rr_pick (inputs req vector and pointer; output one-hot grant and index).

Test Plan:
1. rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_*=0 throughout. After release, the first grant goes to requester 0.
2. Only requester 2 valid, a=4'b0111, b=4'b0110, rsp_ready=1 -> req_ready=4'b0100 in cycle t; rsp_valid=1 at t+2 with rsp_id=2, gt=1, eq=0, lt=0; rsp_valid low at t+3.
3. All 4 valid and held, pairs (0,0)/(1,0)/(2,3)/(15,1) -> grants in order 0,1,2,3,0. Responses are eq, gt, lt, gt with matching rsp_id.
4. rsp_ready=0 for 5 cycles after rsp_valid rises (a=4'b0000, b=4'b1111) -> rsp_valid, rsp_id and lt=1 stay stable. req_ready stays 0 during the stall. The next grant comes 1 cycle after rsp_ready=1.
5. rst asserted in COMPARE, then in RESPOND -> next cycle state=IDLE, rsp_valid=0, rr_ptr=0. The dropped request produces no response.
6. Requester 1 valid for one cycle while requester 0 is being served, then withdrawn -> requester 1 is never granted, and no spurious response is produced.
